simplez_ram_arbiter: RTL and testbench

//  Shares the single-port Simplez RAM (genram, AW=9, DW=12, 1-cycle registered read) between
//  two requesters: the CPU core (port C) and the serial program loader / debug port (port L).

---
 rtl/simplez_pkg.sv | 20 ++
 rtl/simplez_ram_arbiter_if.sv | 15 +
 rtl/simplez_arb_starve_ctr.sv | 35 +++
 rtl/simplez_ram_arbiter.sv | 127 ++++++++++++
 tb/tb_simplez_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simplez_pkg.sv
// rtl/simplez_pkg.sv - shared types and defaults for the Simplez RAM arbiter
package simplez_pkg;

  localparam int DEF_AW          = 9;
  localparam int DEF_DW          = 12;
  localparam int DEF_STARVE_MAX  = 8;
  localparam int DEF_PERIPH_BASE = 'h1F8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_C = 1'b0,
    OWNER_L = 1'b1
  } owner_e;

endpackage

// File: rtl/simplez_ram_arbiter_if.sv
// rtl/simplez_ram_arbiter_if.sv - request/ack memory port shared by the CPU and loader sides
interface simplez_ram_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 12
);
  logic          req;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, rw, addr, wdata, input ack, rdata);
  modport slave  (input req, rw, addr, wdata, output ack, rdata);
endinterface

// File: rtl/simplez_arb_starve_ctr.sv
// rtl/simplez_arb_starve_ctr.sv - saturating count of cycles the loader has been kept waiting
module simplez_arb_starve_ctr #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic full
);
  localparam int            CW    = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_V = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full = (cnt_q == MAX_V);
endmodule

// File: rtl/simplez_ram_arbiter.sv
// rtl/simplez_ram_arbiter.sv - shares the single-port Simplez RAM between the CPU and the loader
module simplez_ram_arbiter
  import simplez_pkg::*;
#(
  parameter int            AW          = DEF_AW,
  parameter int            DW          = DEF_DW,
  parameter int            STARVE_MAX  = DEF_STARVE_MAX,
  parameter logic [AW-1:0] PERIPH_BASE = AW'(DEF_PERIPH_BASE)
) (
  input  logic                 clk,
  input  logic                 rst,
  simplez_ram_arbiter_if.slave c_bus,
  simplez_ram_arbiter_if.slave l_bus,
  input  logic                 l_lock,
  output logic                 ram_cs,
  output logic                 ram_rw,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_din,
  input  logic [DW-1:0]        ram_dout,
  output logic                 c_wait
);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          req_rw_q, req_rw_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [DW-1:0] req_wdata_q, req_wdata_d;

  logic grant_c;
  logic grant_l;
  logic starve_full;
  logic periph;
  logic in_access;
  logic in_done;
  logic [DW-1:0] rd_data;

  // Arbitration runs whenever the RAM is free next cycle, i.e. IDLE and DONE.
  always_comb begin
    grant_c = 1'b0;
    grant_l = 1'b0;
    if (state_q != ST_ACCESS) begin
      if (l_lock) begin
        grant_l = l_bus.req;
      end else if (starve_full && l_bus.req) begin
        grant_l = 1'b1;
      end else if (c_bus.req) begin
        grant_c = 1'b1;
      end else if (l_bus.req) begin
        grant_l = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_rw_d    = req_rw_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    case (state_q)
      ST_ACCESS: state_d = ST_DONE;
      default: begin
        if (grant_l) begin
          state_d     = ST_ACCESS;
          owner_d     = OWNER_L;
          req_rw_d    = l_bus.rw;
          req_addr_d  = l_bus.addr;
          req_wdata_d = l_bus.wdata;
        end else if (grant_c) begin
          state_d     = ST_ACCESS;
          owner_d     = OWNER_C;
          req_rw_d    = c_bus.rw;
          req_addr_d  = c_bus.addr;
          req_wdata_d = c_bus.wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_C;
      req_rw_q    <= 1'b1;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  simplez_arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (l_bus.req && !grant_l),
    .clr (!l_bus.req || grant_l),
    .full(starve_full)
  );

  assign periph    = (req_addr_q >= PERIPH_BASE);
  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);

  // Not gated by rst: an access already on the bus finishes at the reset edge.
  assign ram_cs   = in_access && !periph;
  assign ram_rw   = in_access ? req_rw_q : 1'b1;
  assign ram_addr = in_access ? req_addr_q : '0;
  assign ram_din  = in_access ? req_wdata_q : '0;

  assign rd_data = (req_rw_q && !periph) ? ram_dout : '0;

  assign c_bus.ack   = in_done && (owner_q == OWNER_C);
  assign l_bus.ack   = in_done && (owner_q == OWNER_L);
  assign c_bus.rdata = c_bus.ack ? rd_data : '0;
  assign l_bus.rdata = l_bus.ack ? rd_data : '0;

  assign c_wait = c_bus.req && !c_bus.ack;

endmodule

// File: tb/tb_simplez_ram_arbiter.sv
// tb/tb_simplez_ram_arbiter.sv - directed and randomized checks of simplez_ram_arbiter
module tb_simplez_ram_arbiter;
  import simplez_pkg::*;

  localparam int         AW   = 9;
  localparam int         DW   = 12;
  localparam int         SMAX = 8;
  localparam logic [8:0] PB   = 9'h1F8;

  logic          clk = 1'b0;
  logic          rst;
  logic          l_lock;
  logic          ram_cs, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          c_wait;

  int checks = 0;
  int errors = 0;
  int cs_cnt = 0;

  logic [DW-1:0] mem   [0:511];
  logic [DW-1:0] model [0:511];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  simplez_ram_arbiter_if #(.AW(AW), .DW(DW)) cb ();
  simplez_ram_arbiter_if #(.AW(AW), .DW(DW)) lb ();

  simplez_ram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX), .PERIPH_BASE(PB)) dut (
    .clk(clk), .rst(rst), .c_bus(cb), .l_bus(lb), .l_lock(l_lock),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .c_wait(c_wait)
  );

  always #5 clk = ~clk;

  // genram stand-in: 1-cycle registered read, plus a bench-only preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_cs && !ram_rw) mem[ram_addr] <= ram_din;
    if (ram_cs && ram_rw) ram_dout <= mem[ram_addr];
    if (ram_cs) cs_cnt <= cs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return (a >= PB) ? '0 : model[a];
  endfunction

  task automatic drive(input bit p, input bit req, input bit rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    if (p) begin
      lb.req = req; lb.rw = rw; lb.addr = a; lb.wdata = wd;
    end else begin
      cb.req = req; cb.rw = rw; cb.addr = a; cb.wdata = wd;
    end
  endtask

  task automatic access(input bit p, input bit rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int exp_lat, input string tag);
    int lat = 0;
    bit got = 1'b0;
    drive(p, 1'b1, rw, a, wd);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if ((p ? lb.ack : cb.ack) === 1'b1) got = 1'b1;
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
      if (rw) check({tag, "_rdata"}, p ? lb.rdata : cb.rdata, exp_rd(a));
      else if (a < PB) model[a] = wd;
    end
    drive(p, 1'b0, rw, a, wd);
  endtask

  initial begin
    int cs0, nacks, c_first, lcnt, waited, diffs;
    bit seen_l, got;
    bit act [2];
    bit rrw [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rwd [2];
    int age [2];
    logic [DW-1:0] saved;
    bit [1:0] ackseq [$];

    rst = 1'b1;
    l_lock = 1'b0;
    drive(0, 1'b1, 1'b1, '0, '0);
    drive(1, 1'b0, 1'b1, '0, '0);
    // Preload RAM and reference with random contents while reset is held
    pre_we = 1'b1;
    for (int i = 0; i < 512; i++) begin
      pre_addr = AW'(i);
      pre_data = DW'($urandom);
      if (i == 'h010) pre_data = 12'hABC;
      model[i] = pre_data;
      @(negedge clk);
    end
    pre_we = 1'b0;
    @(negedge clk);
    check("rst_c_ack", cb.ack, 0);
    check("rst_l_ack", lb.ack, 0);
    check("rst_c_rdata", cb.rdata, 0);
    check("rst_l_rdata", lb.rdata, 0);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ram_rw", ram_rw, 1);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_c_wait_hi", c_wait, 1);
    cb.req = 1'b0;
    @(negedge clk);
    check("rst_c_wait_lo", c_wait, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: C read of 0x010
    drive(0, 1'b1, 1'b1, 9'h010, '0);
    @(negedge clk);
    check("t1_cs_access", ram_cs, 1);
    check("t1_addr", ram_addr, 9'h010);
    check("t1_no_early_ack", cb.ack, 0);
    @(negedge clk);
    check("t1_ack", cb.ack, 1);
    check("t1_rdata", cb.rdata, 12'hABC);
    check("t1_cs_done", ram_cs, 0);
    drive(0, 1'b0, 1'b1, 9'h010, '0);
    @(negedge clk);
    check("t1_ack_pulse", cb.ack, 0);

    // 2: both held; L must win once its wait reaches SMAX cycles (2 per arbitration)
    drive(0, 1'b1, 1'b1, 9'h030, '0);
    drive(1, 1'b1, 1'b1, 9'h040, '0);
    for (int i = 0; i < 60 && ackseq.size() < 8; i++) begin
      @(negedge clk);
      if (cb.ack === 1'b1) begin
        ackseq.push_back(2'd1);
        check("t2_c_rdata", cb.rdata, exp_rd(9'h030));
      end
      if (lb.ack === 1'b1) begin
        ackseq.push_back(2'd2);
        check("t2_l_rdata", lb.rdata, exp_rd(9'h040));
      end
    end
    drive(0, 1'b0, 1'b1, 9'h030, '0);
    drive(1, 1'b0, 1'b1, 9'h040, '0);
    c_first = 0;
    seen_l = 1'b0;
    foreach (ackseq[i]) if (!seen_l) begin
      if (ackseq[i] == 2'd2) seen_l = 1'b1;
      else c_first++;
    end
    check("t2_l_granted", 32'(seen_l), 1);
    check("t2_c_before_l", c_first, (SMAX + 1) / 2);
    check("t2_c_resumes", (ackseq.size() > c_first + 1) ? 32'(ackseq[c_first + 1]) : 0, 1);
    check("t2_acks", ackseq.size(), 8);
    @(negedge clk);
    @(negedge clk);

    // 3: locked program load while C keeps requesting
    l_lock = 1'b1;
    drive(0, 1'b1, 1'b1, 9'h005, '0);
    lcnt = 0;
    drive(1, 1'b1, 1'b0, 9'h000, 12'h7FF);
    for (int i = 0; i < 100 && lcnt < 16; i++) begin
      @(negedge clk);
      check("t3_no_c_ack", cb.ack, 0);
      check("t3_c_wait", c_wait, 1);
      if (lb.ack === 1'b1) begin
        model[lcnt] = 12'h7FF;
        lcnt++;
        if (lcnt < 16) drive(1, 1'b1, 1'b0, AW'(lcnt), 12'h7FF);
        else begin
          drive(1, 1'b0, 1'b0, '0, '0);
          l_lock = 1'b0;
        end
      end
    end
    check("t3_l_writes", lcnt, 16);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (cb.ack === 1'b1) begin
        got = 1'b1;
        check("t3_c_rdata", cb.rdata, 12'h7FF);
      end
    end
    check("t3_c_ack_after_unlock", 32'(got), 1);
    drive(0, 1'b0, 1'b1, '0, '0);
    @(negedge clk);

    // 4: peripheral-space write never touches the RAM
    saved = mem[9'h1FB];
    cs0 = cs_cnt;
    access(0, 1'b0, 9'h1FB, 12'h123, 2, "t4_periph_wr");
    access(0, 1'b1, 9'h1FB, '0, 2, "t4_periph_rd");
    @(negedge clk);
    check("t4_no_cs", cs_cnt - cs0, 0);
    check("t4_ram_kept", mem[9'h1FB], saved);

    // 5: reset during the ACCESS of a C write
    drive(0, 1'b1, 1'b0, 9'h020, 12'h456);
    drive(1, 1'b1, 1'b1, 9'h050, '0);
    @(negedge clk);
    check("t5_cs", ram_cs, 1);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 9'h020, 12'h456);
    @(negedge clk);
    check("t5_no_ack", cb.ack, 0);
    check("t5_idle", dut.state_q, ST_IDLE);
    check("t5_starve", dut.u_starve.cnt_q, 0);
    check("t5_ram_written", mem[9'h020], 12'h456);
    model[9'h020] = 12'h456;
    rst = 1'b0;
    drive(1, 1'b0, 1'b1, 9'h050, '0);
    @(negedge clk);
    check("t5_no_late_ack", cb.ack, 0);

    // 6: request withdrawn and address changed right after grant
    drive(0, 1'b1, 1'b1, 9'h0AA, '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 9'h155, '0);
    check("t6_addr_latched", ram_addr, 9'h0AA);
    @(negedge clk);
    check("t6_ack", cb.ack, 1);
    check("t6_rdata", cb.rdata, exp_rd(9'h0AA));
    @(negedge clk);
    check("t6_ack_pulse", cb.ack, 0);

    // Randomized traffic on both ports against the memory model
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; age[p] = 0; rrw[p] = 1'b1; raddr[p] = '0; rwd[p] = '0;
    end
    nacks = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      check("rnd_c_wait", c_wait, cb.req && !cb.ack);
      for (int p = 0; p < 2; p++) begin
        got = (p == 1) ? lb.ack : cb.ack;
        if (act[p]) begin
          if (got) begin
            if (rrw[p]) check("rnd_rdata", (p == 1) ? lb.rdata : cb.rdata, exp_rd(raddr[p]));
            else if (raddr[p] < PB) model[raddr[p]] = rwd[p];
            act[p] = 1'b0;
            nacks++;
          end else begin
            age[p]++;
            waited = age[p];
            if (waited > 30) begin
              check("rnd_timeout", waited, 0);
              act[p] = 1'b0;
            end
          end
        end else begin
          check("rnd_spurious_ack", got, 0);
        end
        if (!act[p] && $urandom_range(2) == 0) begin
          act[p] = 1'b1;
          age[p] = 0;
          rrw[p] = $urandom_range(1) == 1;
          raddr[p] = ($urandom_range(7) == 0) ? AW'(PB + $urandom_range(7)) : AW'($urandom_range(PB - 1));
          rwd[p] = DW'($urandom);
        end
        drive(p[0], act[p], rrw[p], raddr[p], rwd[p]);
      end
    end
    drive(0, 1'b0, 1'b1, '0, '0);
    drive(1, 1'b0, 1'b1, '0, '0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rnd_progress", 32'(nacks > 200), 1);
    diffs = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== model[i]) diffs++;
    check("final_memory", diffs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
